arith_batch_engine: RTL and testbench

Batch arithmetic test engine for the accelerator datapath bring-up flow. It fetches a run of 512-bit input lines through a line-granular read port. Each line is unpacked into LANES operand pairs, which are processed by LANES parallel pipelined arithmetic lanes in a selectable mode. Results are packed into output lines, and a final status line carries the completion flag, line count, error code and optional overflow map. The engine sits between the CSR/memory glue of the AFU and the arithmetic units under test, and replaces the single-pair, fixed-wait, single-operation harness.

---
 rtl/arith_batch_engine_pkg.sv | 56 +++++
 rtl/arith_batch_engine_lane.sv | 98 +++++++++
 rtl/arith_batch_engine.sv | 210 +++++++++++++++++++++
 tb/tb_arith_batch_engine.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_batch_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arith_batch_pkg
// Brief    : Shared types, status-line layout and error codes for the
//            arith_batch_engine and its lanes.
// Revision : 1.0 - initial release
// ============================================================================
package arith_batch_pkg;

    // Operation select as seen on op_sel
    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_RSVD = 2'd3
    } t_op_sel;

    // Engine control states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        EXEC    = 3'd3,
        DRAIN   = 3'd4,
        WR_REQ  = 3'd5,
        STATUS  = 3'd6,
        DONE    = 3'd7
    } t_state;

    localparam int LINE_W         = 512;
    localparam int STAT_FIELD_W   = 32;
    localparam int STAT_FLAG_LSB  = 0;
    localparam int STAT_COUNT_LSB = 32;
    localparam int STAT_ERR_LSB   = 64;
    localparam int STAT_OVF_LSB   = 96;

    localparam logic [STAT_FIELD_W-1:0] ERR_OK     = 32'd0;
    localparam logic [STAT_FIELD_W-1:0] ERR_BAD_OP = 32'd1;

    // Assemble the final status line; every bit not named here is zero
    function automatic logic [LINE_W-1:0] status_line(
        input logic [STAT_FIELD_W-1:0] count,
        input logic [STAT_FIELD_W-1:0] err,
        input logic [STAT_FIELD_W-1:0] ovf_map
    );
        logic [LINE_W-1:0] line;
        line = '0;
        line[STAT_FLAG_LSB  +: STAT_FIELD_W] = 32'd1;
        line[STAT_COUNT_LSB +: STAT_FIELD_W] = count;
        line[STAT_ERR_LSB   +: STAT_FIELD_W] = err;
        line[STAT_OVF_LSB   +: STAT_FIELD_W] = ovf_map;
        return line;
    endfunction

endpackage : arith_batch_pkg
`default_nettype wire

// File: rtl/arith_batch_engine_lane.sv
`default_nettype none
// ============================================================================
// Module   : arith_batch_lane
// Brief    : One arithmetic lane (mul low half / add / sub, all wrapping),
//            followed by a PIPELINE_STAGE-deep register chain.
//            ARITH_BATCH_OVERFLOW_EN adds a per-lane overflow flag
//            (mul upper half nonzero, add carry-out, sub borrow).
// Revision : 1.0 - initial release
// ============================================================================
module arith_batch_lane
    import arith_batch_pkg::*;
#(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  t_op_sel             op,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic [DATA_LEN-1:0] result,
    output logic                overflow
);

    logic [DATA_LEN-1:0]       res_d;
    logic                      ovf_d;
    logic [DATA_LEN-1:0]       res_q [PIPELINE_STAGE];
    logic [PIPELINE_STAGE-1:0] ovf_q;

`ifdef ARITH_BATCH_OVERFLOW_EN
    logic [2*DATA_LEN-1:0] prod_w;
    logic [DATA_LEN:0]     sum_w;
    logic [DATA_LEN:0]     diff_w;

    assign prod_w = {{DATA_LEN{1'b0}}, a} * {{DATA_LEN{1'b0}}, b};
    assign sum_w  = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the borrow (a < b)
    assign diff_w = {1'b0, a} - {1'b0, b};

    // Full-width arithmetic: low half is the result, upper bits the flag
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (op)
            OP_MUL: begin
                res_d = prod_w[DATA_LEN-1:0];
                ovf_d = |prod_w[2*DATA_LEN-1:DATA_LEN];
            end
            OP_ADD: begin
                res_d = sum_w[DATA_LEN-1:0];
                ovf_d = sum_w[DATA_LEN];
            end
            OP_SUB: begin
                res_d = diff_w[DATA_LEN-1:0];
                ovf_d = diff_w[DATA_LEN];
            end
            default: begin
                res_d = '0;
                ovf_d = 1'b0;
            end
        endcase
    end
`else
    // Low-half arithmetic only; no overflow tracking
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (op)
            OP_MUL:  res_d = a * b;
            OP_ADD:  res_d = a + b;
            OP_SUB:  res_d = a - b;
            default: res_d = '0;
        endcase
    end
`endif

    // Delay result and flag by exactly PIPELINE_STAGE clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < PIPELINE_STAGE; s++) begin
                res_q[s] <= '0;
            end
            ovf_q <= '0;
        end else begin
            res_q[0] <= res_d;
            ovf_q[0] <= ovf_d;
            for (int s = 1; s < PIPELINE_STAGE; s++) begin
                res_q[s] <= res_q[s-1];
                ovf_q[s] <= ovf_q[s-1];
            end
        end
    end

    assign result   = res_q[PIPELINE_STAGE-1];
    assign overflow = ovf_q[PIPELINE_STAGE-1];

endmodule : arith_batch_lane
`default_nettype wire

// File: rtl/arith_batch_engine.sv
`default_nettype none
// ============================================================================
// Module   : arith_batch_engine
// Brief    : Fetches num_lines 512-bit lines, runs LANES operand pairs per
//            line through pipelined lanes, writes one result line per input
//            line and a trailing status line. One read outstanding at a time.
//            Build option: ARITH_BATCH_OVERFLOW_EN (overflow map in status).
// Revision : 1.0 - initial release
// ============================================================================
module arith_batch_engine
    import arith_batch_pkg::*;
#(
    parameter int DATA_LEN       = 32,
    parameter int LANES          = 8,
    parameter int PIPELINE_STAGE = 2,
    parameter int ADDR_W         = 42,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op_sel,
    input  logic [ADDR_W-1:0]  in_base,
    input  logic [ADDR_W-1:0]  out_base,
    input  logic [CNT_W-1:0]   num_lines,
    output logic               rd_req_valid,
    output logic [ADDR_W-1:0]  rd_req_addr,
    input  logic               rd_req_ready,
    input  logic               rd_rsp_valid,
    input  logic [511:0]       rd_rsp_data,
    output logic               wr_req_valid,
    output logic [ADDR_W-1:0]  wr_req_addr,
    output logic [511:0]       wr_req_data,
    input  logic               wr_req_ready,
    output logic               busy,
    output logic               done
);

    if (2 * LANES * DATA_LEN > 512 || LANES > 32) begin : g_bad_cfg
        $error("arith_batch_engine: LANES/DATA_LEN do not fit a 512-bit line");
    end

    t_state                    state_q, state_d;
    t_op_sel                   op_q;
    logic [ADDR_W-1:0]         in_base_q, out_base_q;
    logic [CNT_W-1:0]          num_q, idx_q, idx_next_w;
    logic [STAT_FIELD_W-1:0]   err_q;
    logic [LINE_W-1:0]         line_q;
    logic [PIPELINE_STAGE-1:0] tag_q;
    logic [LANES-1:0]          ovf_map_q;

    logic                      rd_req_valid_q, wr_req_valid_q, busy_q, done_q;
    logic [ADDR_W-1:0]         rd_req_addr_q, wr_req_addr_q;
    logic [LINE_W-1:0]         wr_req_data_q;

    logic [DATA_LEN-1:0]       lane_res [LANES];
    logic [LANES-1:0]          lane_ovf;
    logic [LINE_W-1:0]         res_line_w;
    logic                      start_skip_w;

    assign idx_next_w   = idx_q + CNT_W'(1);
    assign start_skip_w = (num_lines == '0) || (t_op_sel'(op_sel) == OP_RSVD);

    // Lanes read straight from the captured line; the tag marks when the
    // value launched in EXEC has reached the last pipeline stage
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        arith_batch_lane #(
            .DATA_LEN       (DATA_LEN),
            .PIPELINE_STAGE (PIPELINE_STAGE)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .op       (op_q),
            .a        (line_q[2*i*DATA_LEN +: DATA_LEN]),
            .b        (line_q[(2*i+1)*DATA_LEN +: DATA_LEN]),
            .result   (lane_res[i]),
            .overflow (lane_ovf[i])
        );
    end

    // Pack lane results into an output line, upper bits left zero
    always_comb begin
        res_line_w = '0;
        for (int i = 0; i < LANES; i++) begin
            res_line_w[i*DATA_LEN +: DATA_LEN] = lane_res[i];
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = start_skip_w ? STATUS : RD_REQ;
            RD_REQ:  if (rd_req_ready) state_d = RD_WAIT;
            RD_WAIT: if (rd_rsp_valid) state_d = EXEC;
            EXEC:    state_d = DRAIN;
            DRAIN:   if (tag_q[PIPELINE_STAGE-1]) state_d = WR_REQ;
            WR_REQ:  if (wr_req_ready) state_d = (idx_next_w < num_q) ? RD_REQ : STATUS;
            STATUS:  if (wr_req_valid_q && wr_req_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Valid tag travels alongside the lane pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= (state_q == EXEC);
            for (int s = 1; s < PIPELINE_STAGE; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    // State, run context and registered request outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            op_q           <= OP_MUL;
            in_base_q      <= '0;
            out_base_q     <= '0;
            num_q          <= '0;
            idx_q          <= '0;
            err_q          <= ERR_OK;
            line_q         <= '0;
            ovf_map_q      <= '0;
            rd_req_valid_q <= 1'b0;
            rd_req_addr_q  <= '0;
            wr_req_valid_q <= 1'b0;
            wr_req_addr_q  <= '0;
            wr_req_data_q  <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q       <= t_op_sel'(op_sel);
                        in_base_q  <= in_base;
                        out_base_q <= out_base;
                        num_q      <= num_lines;
                        idx_q      <= '0;
                        ovf_map_q  <= '0;
                        err_q      <= (t_op_sel'(op_sel) == OP_RSVD) ? ERR_BAD_OP : ERR_OK;
                        busy_q     <= 1'b1;
                        if (!start_skip_w) begin
                            rd_req_valid_q <= 1'b1;
                            rd_req_addr_q  <= in_base;
                        end
                    end
                end
                RD_REQ: begin
                    if (rd_req_ready) rd_req_valid_q <= 1'b0;
                end
                RD_WAIT: begin
                    if (rd_rsp_valid) line_q <= rd_rsp_data;
                end
                DRAIN: begin
                    if (tag_q[PIPELINE_STAGE-1]) begin
                        wr_req_valid_q <= 1'b1;
                        wr_req_addr_q  <= out_base_q + ADDR_W'(idx_q);
                        wr_req_data_q  <= res_line_w;
                        ovf_map_q      <= ovf_map_q | lane_ovf;
                    end
                end
                WR_REQ: begin
                    if (wr_req_ready) begin
                        wr_req_valid_q <= 1'b0;
                        idx_q          <= idx_next_w;
                        if (idx_next_w < num_q) begin
                            rd_req_valid_q <= 1'b1;
                            rd_req_addr_q  <= in_base_q + ADDR_W'(idx_next_w);
                        end
                    end
                end
                STATUS: begin
                    // First cycle loads the status line so valid drops for a
                    // cycle after the last data write was accepted
                    if (!wr_req_valid_q) begin
                        wr_req_valid_q <= 1'b1;
                        wr_req_addr_q  <= out_base_q + ADDR_W'(num_q);
                        wr_req_data_q  <= status_line(STAT_FIELD_W'(idx_q), err_q,
                                                      STAT_FIELD_W'(ovf_map_q));
                    end else if (wr_req_ready) begin
                        wr_req_valid_q <= 1'b0;
                        done_q         <= 1'b1;
                        busy_q         <= 1'b0;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rd_req_valid = rd_req_valid_q;
    assign rd_req_addr  = rd_req_addr_q;
    assign wr_req_valid = wr_req_valid_q;
    assign wr_req_addr  = wr_req_addr_q;
    assign wr_req_data  = wr_req_data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule : arith_batch_engine
`default_nettype wire

// File: tb/tb_arith_batch_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_arith_batch_engine
// Brief    : Scoreboard bench for arith_batch_engine. A line-level model
//            predicts reads and writes; a negedge monitor compares handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arith_batch_engine;

    localparam int DL = 32;
    localparam int LN = 8;
    localparam int PS = 2;
    localparam int AW = 42;
    localparam int CW = 16;
`ifdef ARITH_BATCH_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op_sel = '0;
    logic [AW-1:0] in_base = '0;
    logic [AW-1:0] out_base = '0;
    logic [CW-1:0] num_lines = '0;
    logic          rd_req_valid, wr_req_valid, busy, done;
    logic [AW-1:0] rd_req_addr, wr_req_addr;
    logic [511:0]  wr_req_data;
    logic          rd_req_ready, rd_rsp_valid, wr_req_ready;
    logic [511:0]  rd_rsp_data;

    always #5 clk = ~clk;

    arith_batch_engine #(
        .DATA_LEN(DL), .LANES(LN), .PIPELINE_STAGE(PS), .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .op_sel(op_sel),
        .in_base(in_base), .out_base(out_base), .num_lines(num_lines),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_req_ready(wr_req_ready), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_rsp_cyc = -1;
    int wr_hold = 0;
    bit auto_rsp = 1'b1;
    bit inject_stray = 1'b0;
    bit stray = 1'b0;

    logic [511:0]  mem [logic [AW-1:0]];
    logic [AW-1:0] exp_rd_q[$];
    logic [AW-1:0] exp_wa_q[$];
    logic [511:0]  exp_wd_q[$];
    logic [AW-1:0] rd_pend[$];
    logic [511:0]  wr_log[$];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory/ready driver: random ready, delayed read responses, stray pulses
    initial begin
        logic [AW-1:0] a;
        rd_req_ready = 1'b0;
        wr_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            rd_req_ready = ($urandom_range(0, 3) != 0);
            if (wr_hold > 0) begin
                wr_req_ready = 1'b0;
                if (wr_req_valid) begin
                    wr_hold--;
                    if (wr_hold == 5) inject_stray = 1'b1;
                end
            end else begin
                wr_req_ready = ($urandom_range(0, 3) != 0);
            end
            rd_rsp_valid = 1'b0;
            stray = 1'b0;
            if (inject_stray) begin
                inject_stray = 1'b0;
                stray = 1'b1;
                rd_rsp_valid = 1'b1;
                rd_rsp_data = {16{$urandom}};
            end else if (auto_rsp && rd_pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                a = rd_pend.pop_front();
                rd_rsp_valid = 1'b1;
                rd_rsp_data = mem.exists(a) ? mem[a] : '0;
            end
        end
    end

    // Monitor: handshakes complete at the next posedge when seen here
    initial begin
        bit            prev_rd = 1'b0, prev_wr = 1'b0, wr_valid_last = 1'b0;
        logic [AW-1:0] prev_rd_addr, prev_wr_addr;
        logic [511:0]  prev_wr_data;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_rd = 1'b0; prev_wr = 1'b0; wr_valid_last = 1'b0; last_rsp_cyc = -1;
            end else begin
                if (prev_rd) begin
                    check("rd_hold_valid", rd_req_valid, 1);
                    check("rd_hold_addr", rd_req_addr, prev_rd_addr);
                end
                if (prev_wr) begin
                    check("wr_hold_valid", wr_req_valid, 1);
                    check("wr_hold_addr", wr_req_addr, prev_wr_addr);
                    check("wr_hold_data", wr_req_data, prev_wr_data);
                end
                if (rd_rsp_valid && !stray) last_rsp_cyc = cyc;
                if (wr_req_valid && !wr_valid_last && last_rsp_cyc >= 0) begin
                    check("rsp_to_write_latency", cyc - last_rsp_cyc, 2 + PS);
                    last_rsp_cyc = -1;
                end
                if (rd_req_valid && rd_req_ready) begin
                    if (exp_rd_q.size() == 0) begin
                        check("unexpected_read", rd_req_addr, 0);
                        if (rd_req_addr == 0) begin
                            errors++;
                            $display("FAIL unexpected_read: got addr 0 expected no read");
                        end
                    end else begin
                        check("rd_addr", rd_req_addr, exp_rd_q.pop_front());
                    end
                    rd_pend.push_back(rd_req_addr);
                end
                if (wr_req_valid && wr_req_ready) begin
                    wr_log.push_back(wr_req_data);
                    if (exp_wa_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %0h expected no write", wr_req_addr);
                    end else begin
                        check("wr_addr", wr_req_addr, exp_wa_q.pop_front());
                        check("wr_data", wr_req_data, exp_wd_q.pop_front());
                    end
                end
                if (done) done_cnt++;
                prev_rd = rd_req_valid && !rd_req_ready;
                prev_wr = wr_req_valid && !wr_req_ready;
                prev_rd_addr = rd_req_addr;
                prev_wr_addr = wr_req_addr;
                prev_wr_data = wr_req_data;
                wr_valid_last = wr_req_valid;
            end
        end
    end

    function automatic logic [511:0] rnd_line();
        logic [511:0] l;
        for (int w = 0; w < 16; w++) begin
            case ($urandom_range(0, 7))
                0:       l[w*32 +: 32] = 32'h0;
                1:       l[w*32 +: 32] = 32'hFFFF_FFFF;
                2:       l[w*32 +: 32] = 32'h1;
                default: l[w*32 +: 32] = $urandom;
            endcase
        end
        return l;
    endfunction

    task automatic fill_lines(input logic [AW-1:0] inb, input int n);
        for (int i = 0; i < n; i++) mem[inb + AW'(i)] = rnd_line();
    endtask

    task automatic set_pair(input logic [AW-1:0] addr, input int lane,
                            input logic [31:0] a, input logic [31:0] b);
        logic [511:0] l;
        l = mem[addr];
        l[2*lane*DL +: DL] = a;
        l[(2*lane+1)*DL +: DL] = b;
        mem[addr] = l;
    endtask

    // Line-level reference: what the engine should read and write for a run
    task automatic model_run(input int op, input logic [AW-1:0] inb,
                             input logic [AW-1:0] outb, input int n);
        logic [31:0]  map, a, b, r;
        logic [63:0]  full;
        logic [511:0] l, o;
        logic         ov;
        int           cnt;
        map = '0;
        cnt = 0;
        if (op != 3) begin
            cnt = n;
            for (int i = 0; i < n; i++) begin
                l = mem[inb + AW'(i)];
                o = '0;
                for (int k = 0; k < LN; k++) begin
                    a = l[2*k*DL +: DL];
                    b = l[(2*k+1)*DL +: DL];
                    case (op)
                        0: begin full = 64'(a) * 64'(b); r = full[31:0]; ov = (full[63:32] != 0); end
                        1: begin full = 64'(a) + 64'(b); r = full[31:0]; ov = full[32]; end
                        default: begin r = a - b; ov = (a < b); end
                    endcase
                    o[k*DL +: DL] = r;
                    if (OVF_EN && ov) map[k] = 1'b1;
                end
                exp_rd_q.push_back(inb + AW'(i));
                exp_wa_q.push_back(outb + AW'(i));
                exp_wd_q.push_back(o);
            end
        end
        o = '0;
        o[31:0]   = 32'd1;
        o[63:32]  = 32'(cnt);
        o[95:64]  = (op == 3) ? 32'd1 : 32'd0;
        o[127:96] = map;
        exp_wa_q.push_back(outb + AW'(n));
        exp_wd_q.push_back(o);
    endtask

    task automatic run_case(input int op, input logic [AW-1:0] inb,
                            input logic [AW-1:0] outb, input int n);
        int d0, k;
        wr_log.delete();
        model_run(op, inb, outb, n);
        d0 = done_cnt;
        @(posedge clk); #1;
        op_sel = 2'(op); in_base = inb; out_base = outb; num_lines = CW'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_sel = 2'($urandom); in_base = AW'({$urandom, $urandom});
        out_base = AW'({$urandom, $urandom}); num_lines = CW'($urandom);
        check("busy_after_start", busy, 1);
        check("rd_valid_after_start", rd_req_valid, (n > 0 && op != 3) ? 1 : 0);
        k = 0;
        while (done_cnt == d0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done_cnt - d0, 1);
        repeat (3) @(negedge clk);
        check("single_done_pulse", done_cnt - d0, 1);
        check("busy_after_done", busy, 0);
        check("writes_outstanding", exp_wa_q.size(), 0);
        check("reads_outstanding", exp_rd_q.size(), 0);
    endtask

    task automatic check_reset_vals();
        check("rst_rd_valid", rd_req_valid, 0);
        check("rst_wr_valid", wr_req_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_addr", rd_req_addr, 0);
        check("rst_wr_addr", wr_req_addr, 0);
        check("rst_wr_data", wr_req_data, 0);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;

        // mul, one line
        fill_lines(42'd100, 1);
        set_pair(42'd100, 0, 32'd3, 32'd5);
        set_pair(42'd100, 7, 32'd1000, 32'd7);
        run_case(0, 42'd100, 42'h2000, 1);
        check("t1_log_size", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            check("t1_word0", wr_log[0][31:0], 32'd15);
            check("t1_word7", wr_log[0][255:224], 32'd7000);
            check("t1_count", wr_log[1][63:32], 32'd1);
            check("t1_err", wr_log[1][95:64], 32'd0);
        end

        // sub, three lines, borrow case in lane 0
        fill_lines(42'd300, 3);
        for (int i = 0; i < 3; i++) set_pair(42'd300 + AW'(i), 0, 32'd5, 32'd7);
        run_case(2, 42'd300, 42'h3000, 3);
        check("t2_log_size", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            for (int i = 0; i < 3; i++) check("t2_word0", wr_log[i][31:0], 32'hFFFF_FFFE);
            check("t2_count", wr_log[3][63:32], 32'd3);
        end

        // zero lines and reserved op
        run_case(1, 42'd400, 42'h4000, 0);
        run_case(3, 42'd400, 42'h5000, 4);
        check("t4_err", wr_log.size() > 0 ? wr_log[wr_log.size()-1][95:64] : '1, 32'd1);

        // write back-pressure with a stray response during WR_REQ
        fill_lines(42'd700, 2);
        wr_hold = 10;
        run_case(1, 42'd700, 42'h7000, 2);
        check("t5_hold_consumed", wr_hold, 0);
        check("t5_one_write_per_line", wr_log.size(), 3);

        // reset while waiting for read data, then a late response
        auto_rsp = 1'b0;
        fill_lines(42'd500, 2);
        exp_rd_q.push_back(42'd500);
        @(posedge clk); #1;
        op_sel = 2'd1; in_base = 42'd500; out_base = 42'h6000; num_lines = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (rd_pend.size() == 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t6_read_issued", rd_pend.size(), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        rd_pend.delete();
        exp_rd_q.delete();
        @(posedge clk); #1;
        check_reset_vals();
        reset = 1'b0;
        wr_log.delete();
        @(negedge clk);
        inject_stray = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_write_after_reset", wr_log.size(), 0);
        check("t6_idle_after_reset", busy, 0);
        auto_rsp = 1'b1;
        fill_lines(42'd600, 1);
        set_pair(42'd600, 0, 32'hFFFF_FFFF, 32'd2);
        run_case(1, 42'd600, 42'h6100, 1);
        if (wr_log.size() == 2) begin
            check("t6_word0", wr_log[0][31:0], 32'd1);
            check("t6_ovf_bit96", wr_log[1][96], OVF_EN);
        end else begin
            check("t6_log_size", wr_log.size(), 2);
        end

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            int op, n;
            logic [AW-1:0] inb, outb;
            op = $urandom_range(0, 3);
            n = $urandom_range(0, 4);
            inb = AW'({$urandom, $urandom});
            outb = AW'({$urandom, $urandom});
            fill_lines(inb, n);
            run_case(op, inb, outb, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_arith_batch_engine
`default_nettype wire
